audio_cmd_rx: RTL and testbench
===============================

// Module: audio_cmd_rx
// PURPOSE
//  Receiving end of the 3-wire audio command link (clk/data/reset, idle high). Samples the serial
//  lines, assembles 16-bit command words (LSB first, data sampled on rising clk) and queues them
//  in a small FIFO that the CPU reads over APB3. Used as a loopback monitor and sound-module
//  emulator, including a busy indication after each accepted command.
// PARAMETERS
//  FIFO_DEPTH    4       command words buffered; power of two, 2..16
//  TIMEOUT_CYC   500000  PCLK cycles without a serial clk edge before an open frame is aborted
//  BUSY_CYC      100000  PCLK cycles busy is held high after each completed frame
// PORTS
//  PCLK      in   1   system clock
//  PRESET    in   1   synchronous reset, active-high
//  PSEL      in   1   APB3 peripheral select
//  PENABLE   in   1   APB3 access phase
//  PWRITE    in   1   APB3 write (1) / read (0)
//  PADDR     in   32  APB3 address; only [3:2] decoded
//  PWDATA    in   32  APB3 write data
//  PRDATA    out  32  APB3 read data, combinational from PADDR and state
//  PREADY    out  1   tied 1
//  PSLVERR   out  1   tied 0
//  ser_clk   in   1   serial clock line, async to PCLK
//  ser_data  in   1   serial data line, async to PCLK
//  ser_rst_n in   1   module reset line, active-low, async to PCLK
//  busy      out  1   high while the emulated module is busy
//  irq       out  1   high while the FIFO is non-empty or a sticky error is set
// BEHAVIOUR
//  Reset: FIFO empty, all sticky flags 0, FSM IDLE, busy=0, irq=0. Sync flops reset to 1.
//  Sync: each serial input goes through 2 flops, then a 3rd flop for edge detect. A pin edge is
//   acted on 3 PCLK cycles later.
//  FSM:
//   IDLE:  falling edge of ser_clk -> SHIFT; bit_cnt=0, timer=0.
//   SHIFT: rising edge of ser_clk -> shreg[bit_cnt]=ser_data (synced), bit_cnt++, timer=0.
//          Any ser_clk edge clears timer; otherwise timer++.
//          On the 16th sample -> push word, load busy counter with BUSY_CYC, -> IDLE.
//          timer==TIMEOUT_CYC -> set FERR, discard partial word, -> IDLE.
//  ser_rst_n low (synced): FSM -> IDLE at once, partial word discarded, RSTSEEN set, busy=0.
//   Stays in IDLE until ser_rst_n is high again. FIFO contents are kept.
//  busy: high while busy counter != 0; counter decrements once per cycle.
//  Registers (PADDR[3:2]):
//   0 STATUS  R: [0] not_empty, [1] OVF, [2] FERR, [3] RSTSEEN, [8:4] count, [9] busy
//   1 DATA    R: [15:0] FIFO head, upper bits 0. Read access phase (PSEL&PENABLE&!PWRITE) pops.
//             Empty read returns 0 and does not pop.
//   2 CTRL    W: [0]=1 clears OVF/FERR/RSTSEEN, [1]=1 flushes FIFO. Both apply in the same cycle.
//   3         reads 0; writes ignored. Writes to STATUS/DATA ignored.
//  FIFO: push when full -> word dropped, OVF set. Push and pop in the same cycle -> both occur,
//   count unchanged. Flush in the same cycle as a push -> FIFO ends empty.
//   A sticky set and a clear in the same cycle -> the set wins.
//   Pointers wrap modulo FIFO_DEPTH. count is 0..FIFO_DEPTH.
//  irq = not_empty | OVF | FERR | RSTSEEN.
// TESTING  (TIMEOUT_CYC=200, BUSY_CYC=50, bit period 40 PCLK)
//  Send 0xA55A LSB first -> STATUS count=1, busy high for 50 cycles, DATA read=0x0000A55A,
//   then count=0 and irq=0.
//  Send 5 words 0x0001..0x0005, depth 4 -> DATA reads 1,2,3,4, OVF=1; CTRL write 1 clears OVF.
//  Stop after 7 bits, then idle 250 cycles -> FERR=1, count unchanged. Next full frame 0x1234
//   is received correctly.
//  Pull ser_rst_n low mid-frame, then release -> RSTSEEN=1, busy=0, partial discarded.
//   Next frame 0x00FF is received.
//  DATA pop in the same cycle as a push, with count=2 -> count stays 2 and order is preserved.
//   CTRL=2 -> count=0; DATA read returns 0.

Source files
------------

// File: rtl/audio_cmd_rx_if.sv
// APB3 bus bundle between the CPU-side master and the audio command receiver.
interface audio_cmd_rx_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/audio_cmd_rx.sv
// Audio command link receiver: syncs the 3-wire serial link, assembles 16-bit
// LSB-first words, queues them in a FIFO read over APB3 and emulates module busy.
module audio_cmd_rx #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TIMEOUT_CYC = 500000,
  parameter int unsigned BUSY_CYC    = 100000
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  audio_cmd_rx_if.slave         apb,
  input  logic                  ser_clk,
  input  logic                  ser_data,
  input  logic                  ser_rst_n,
  output logic                  busy,
  output logic                  irq
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned BW = $clog2(BUSY_CYC + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  // Synchroniser chains; idle-high lines so they reset to 1
  logic [2:0] clk_sync_q;
  logic [1:0] dat_sync_q;
  logic [1:0] rst_sync_q;

  logic clk_rise_c, clk_fall_c, data_s_c, link_rst_c;

  state_t          state_q, state_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [14:0]     shreg_q, shreg_d;
  logic [BW-1:0]   busy_cnt_q, busy_cnt_d;
  logic            push_c, ferr_set_c, rst_set_c;
  logic [15:0]     push_word_c;

  logic [15:0]     mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            ovf_q, ferr_q, rstseen_q;

  logic            not_empty_c, full_c, push_ok_c, pop_c, flush_c, clr_c;
  logic            rd_acc_c, wr_acc_c;
  logic [1:0]      addr_c;
  logic            apb_unused;

  // Two-flop sync of each line plus a third flop on ser_clk for edge detection
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      clk_sync_q <= 3'b111;
      dat_sync_q <= 2'b11;
      rst_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[1:0], ser_clk};
      dat_sync_q <= {dat_sync_q[0], ser_data};
      rst_sync_q <= {rst_sync_q[0], ser_rst_n};
    end
  end

  assign clk_rise_c = clk_sync_q[1] & ~clk_sync_q[2];
  assign clk_fall_c = ~clk_sync_q[1] & clk_sync_q[2];
  assign data_s_c   = dat_sync_q[1];
  assign link_rst_c = ~rst_sync_q[1];

  // Frame FSM state and datapath registers
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      timer_q    <= '0;
      shreg_q    <= '0;
      busy_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      timer_q    <= timer_d;
      shreg_q    <= shreg_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  // Frame assembly, inactivity timeout, link reset and busy countdown
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    timer_d     = timer_q;
    shreg_d     = shreg_q;
    busy_cnt_d  = busy_cnt_q;
    push_c      = 1'b0;
    push_word_c = '0;
    ferr_set_c  = 1'b0;
    rst_set_c   = 1'b0;

    if (busy_cnt_q != '0) begin
      busy_cnt_d = busy_cnt_q - 1'b1;
    end

    if (link_rst_c) begin
      state_d    = IDLE;
      bit_cnt_d  = '0;
      timer_d    = '0;
      busy_cnt_d = '0;
      rst_set_c  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (clk_fall_c) begin
            state_d   = SHIFT;
            bit_cnt_d = '0;
            timer_d   = '0;
          end
        end
        SHIFT: begin
          if (clk_rise_c) begin
            // LSB arrives first, so shift right and it settles at bit 0
            shreg_d = {data_s_c, shreg_q[14:1]};
            timer_d = '0;
            if (bit_cnt_q == 4'd15) begin
              push_c      = 1'b1;
              push_word_c = {data_s_c, shreg_q};
              busy_cnt_d  = BW'(BUSY_CYC);
              state_d     = IDLE;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end else if (clk_fall_c) begin
            timer_d = '0;
          end else if (timer_q == TW'(TIMEOUT_CYC)) begin
            ferr_set_c = 1'b1;
            state_d    = IDLE;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign addr_c      = apb.PADDR[3:2];
  assign rd_acc_c    = apb.PSEL & apb.PENABLE & ~apb.PWRITE;
  assign wr_acc_c    = apb.PSEL & apb.PENABLE & apb.PWRITE;
  assign not_empty_c = (count_q != '0);
  assign full_c      = (count_q == CW'(FIFO_DEPTH));
  assign push_ok_c   = push_c & ~full_c;
  assign pop_c       = rd_acc_c & (addr_c == 2'd1) & not_empty_c;
  assign flush_c     = wr_acc_c & (addr_c == 2'd2) & apb.PWDATA[1];
  assign clr_c       = wr_acc_c & (addr_c == 2'd2) & apb.PWDATA[0];
  assign apb_unused  = ^{apb.PADDR[31:4], apb.PADDR[1:0], apb.PWDATA[31:2]};

  // FIFO storage; contents need no reset since count gates every read
  always_ff @(posedge PCLK) begin
    if (push_ok_c) begin
      mem_q[wr_ptr_q] <= push_word_c;
    end
  end

  // FIFO pointers/count and sticky flags; a set beats a same-cycle clear
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      ferr_q    <= 1'b0;
      rstseen_q <= 1'b0;
    end else begin
      if (flush_c) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push_ok_c) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop_c)     rd_ptr_q <= rd_ptr_q + PW'(1);
        count_q <= count_q + CW'(push_ok_c) - CW'(pop_c);
      end
      ovf_q     <= (ovf_q & ~clr_c) | (push_c & full_c);
      ferr_q    <= (ferr_q & ~clr_c) | ferr_set_c;
      rstseen_q <= (rstseen_q & ~clr_c) | rst_set_c;
    end
  end

  // APB read mux, combinational from address and state
  always_comb begin
    apb.PRDATA = '0;
    case (addr_c)
      2'd0: apb.PRDATA = {22'b0, busy, 5'(count_q), rstseen_q, ferr_q, ovf_q, not_empty_c};
      2'd1: if (not_empty_c) apb.PRDATA = {16'b0, mem_q[rd_ptr_q]};
      default: apb.PRDATA = '0;
    endcase
  end

  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = 1'b0;
  assign busy        = (busy_cnt_q != '0);
  assign irq         = not_empty_c | ovf_q | ferr_q | rstseen_q;

endmodule

// File: tb/tb_audio_cmd_rx.sv
// Self-checking bench for audio_cmd_rx against a queue-based reference model.
module tb_audio_cmd_rx;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 200;
  localparam int unsigned BUSYC   = 50;

  logic PCLK      = 1'b0;
  logic PRESET    = 1'b1;
  logic ser_clk   = 1'b1;
  logic ser_data  = 1'b1;
  logic ser_rst_n = 1'b1;
  logic busy;
  logic irq;

  audio_cmd_rx_if apb ();

  audio_cmd_rx #(
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT_CYC(TIMEOUT),
    .BUSY_CYC   (BUSYC)
  ) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .apb      (apb.slave),
    .ser_clk  (ser_clk),
    .ser_data (ser_data),
    .ser_rst_n(ser_rst_n),
    .busy     (busy),
    .irq      (irq)
  );

  always #5 PCLK = ~PCLK;

  int checks   = 0;
  int failures = 0;

  // Reference model: word queue plus sticky flags
  logic [15:0] mq[$];
  bit m_ovf  = 1'b0;
  bit m_ferr = 1'b0;
  bit m_rst  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic void m_push(input logic [15:0] w);
    if (mq.size() == DEPTH) m_ovf = 1'b1;
    else mq.push_back(w);
  endfunction

  function automatic logic [31:0] m_pop();
    if (mq.size() == 0) return 32'h0;
    return {16'h0, mq.pop_front()};
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s      = '0;
    s[0]   = (mq.size() != 0);
    s[1]   = m_ovf;
    s[2]   = m_ferr;
    s[3]   = m_rst;
    s[8:4] = 5'(mq.size());
    return s;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
    tick();
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = a;
    tick();
    apb.PENABLE = 1'b1;
    #1 d = apb.PRDATA;
    tick();
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
  endtask

  task automatic apb_write(input logic [31:0] a, input logic [31:0] v);
    tick();
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1; apb.PADDR = a; apb.PWDATA = v;
    tick();
    apb.PENABLE = 1'b1;
    tick();
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
  endtask

  task automatic chk_data(input string tag);
    logic [31:0] d;
    apb_read(32'h4, d);
    chk(tag, d, m_pop());
  endtask

  task automatic chk_status(input string tag);
    logic [31:0] d;
    apb_read(32'h0, d);
    chk(tag, d & 32'h1FF, m_status());
  endtask

  task automatic ctrl_write(input logic [1:0] v);
    apb_write(32'h8, {30'b0, v});
    if (v[0]) begin m_ovf = 1'b0; m_ferr = 1'b0; m_rst = 1'b0; end
    if (v[1]) mq.delete();
  endtask

  // Drives n bits LSB first; returns right after the last rising clk edge
  task automatic send_bits(input logic [15:0] w, input int n, input int h);
    for (int i = 0; i < n; i++) begin
      ser_clk  = 1'b0;
      ser_data = w[i];
      tick(h);
      ser_clk = 1'b1;
      if (i != n - 1) tick(h);
    end
  endtask

  task automatic send_word(input logic [15:0] w, input int h);
    send_bits(w, 16, h);
    tick(8);
    m_push(w);
  endtask

  task automatic count_busy(input int n, output int c);
    c = 0;
    repeat (n) begin
      tick();
      if (busy) c++;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    int          c;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    apb.PADDR = '0;  apb.PWDATA = '0;

    tick(5);
    PRESET = 1'b0;
    tick(2);
    apb_read(32'h0, d);
    chk("reset_status", d, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_irq", {31'b0, irq}, 32'h0);

    // Single word, busy length, pop, empty afterwards
    send_bits(16'hA55A, 16, 20);
    count_busy(70, c);
    m_push(16'hA55A);
    chk("busy_len", c, BUSYC);
    chk_status("one_word_status");
    chk_data("one_word_data");
    chk_status("one_word_empty");
    chk("one_word_irq", {31'b0, irq}, 32'h0);

    // Overflow on the fifth word
    for (int k = 1; k <= 5; k++) send_word(16'(k), 20);
    chk_status("ovf_status");
    chk("ovf_irq", {31'b0, irq}, 32'h1);
    for (int k = 0; k < 4; k++) chk_data("ovf_data");
    chk_status("ovf_drained");
    ctrl_write(2'b01);
    chk_status("ovf_cleared");
    chk("ovf_irq_clear", {31'b0, irq}, 32'h0);

    // Frame timeout keeps queued words and recovers on next frame
    send_word(16'h0BEE, 20);
    send_bits(16'h0055, 7, 20);
    tick(250);
    m_ferr = 1'b1;
    chk_status("ferr_status");
    send_word(16'h1234, 20);
    chk_data("ferr_data0");
    chk_data("ferr_data1");
    ctrl_write(2'b01);

    // Link reset clears busy, then aborts a partial frame
    send_bits(16'h0F0F, 16, 20);
    tick(10);
    m_push(16'h0F0F);
    chk("busy_before_rst", {31'b0, busy}, 32'h1);
    ser_rst_n = 1'b0;
    tick(5);
    chk("busy_after_rst", {31'b0, busy}, 32'h0);
    ser_rst_n = 1'b1;
    tick(10);
    send_bits(16'hABCD, 8, 20);
    ser_rst_n = 1'b0;
    tick(10);
    ser_rst_n = 1'b1;
    tick(10);
    m_rst = 1'b1;
    chk_status("rst_status");
    send_word(16'h00FF, 20);
    chk_data("rst_data0");
    chk_data("rst_data1");
    ctrl_write(2'b01);

    // Pop lands on the same PCLK edge as the push
    send_word(16'h1111, 20);
    send_word(16'h2222, 20);
    send_bits(16'h3333, 16, 20);
    tick();
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = 32'h4;
    tick();
    apb.PENABLE = 1'b1;
    #1 d = apb.PRDATA;
    chk("pushpop_head", d, m_pop());
    tick();
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
    m_push(16'h3333);
    tick(5);
    chk_status("pushpop_count");
    chk_data("pushpop_order");
    ctrl_write(2'b10);
    chk_status("flush_status");
    chk_data("flush_empty_read");

    // Randomised frames, bit periods and reads
    for (int it = 0; it < 8; it++) begin
      send_word(16'($urandom), int'($urandom_range(5, 25)));
      repeat ($urandom_range(0, 2)) chk_data("rand_data");
      if ($urandom_range(0, 3) == 0) ctrl_write(2'b01);
      chk_status("rand_status");
    end
    while (mq.size() != 0) chk_data("rand_drain");
    chk_status("rand_final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
